// File: rtl/johnson_phase_tracker_if.sv
// Bundle between the Johnson counter source and the phase tracker.
// The master drives the sampled code; the slave (tracker) drives the
// decoded phase, lock status and the revolution/error counters.
interface johnson_phase_tracker_if #(
    parameter int REV_W = 8
);
    logic [7:0]       jc_in;
    logic             jc_valid;
    logic [3:0]       phase;
    logic             phase_valid;
    logic             illegal;
    logic             locked;
    logic             dir;
    logic [REV_W-1:0] rev_count;
    logic [7:0]       err_count;

    modport master (
        output jc_in, jc_valid,
        input  phase, phase_valid, illegal, locked, dir, rev_count, err_count
    );

    modport slave (
        input  jc_in, jc_valid,
        output phase, phase_valid, illegal, locked, dir, rev_count, err_count
    );
endinterface

// File: rtl/johnson_phase_tracker.sv
// Johnson phase tracker: decodes an 8-bit Johnson code to a 4-bit phase,
// checks legality and step sequence, runs a lock FSM and counts
// revolutions and illegal codes.
// Optional build macro JT_REVERSE_EN: accept -1 steps as good steps
// (reverse rotation) with down-counting of revolutions.
//
// state     | meaning
// ----------+---------------------------------------------------------
// ST_UNLOCK | no trusted previous sample; next legal code starts ACQ
// ST_ACQ    | counting consecutive good steps towards LOCK_CNT
// ST_LOCKED | tracking; revolutions are counted on 15<->0 steps
module johnson_phase_tracker #(
    parameter int LOCK_CNT = 4,
    parameter int REV_W    = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    johnson_phase_tracker_if.slave bus
);

    typedef enum logic [1:0] {
        ST_UNLOCK = 2'd0,
        ST_ACQ    = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    state_t           state;
    logic [3:0]       good_cnt;
    logic             have_prev;
    logic [3:0]       phase_q;
    logic             phase_valid_q;
    logic             illegal_q;
    logic             dir_q;
    logic [REV_W-1:0] rev_q;
    logic [7:0]       err_q;

    logic [3:0] pop;
    logic [7:0] inv;
    logic       code_legal;
    logic [3:0] code_phase;
    logic [3:0] step;
    logic       step_fwd;
    logic       step_rev;
    logic       step_move;
    logic       dir_new;
    logic       step_turn;
    logic       step_good;
    logic       step_bad;
    logic       wrap_fwd;
`ifdef JT_REVERSE_EN
    logic       wrap_rev;
`endif

    // Decode the incoming code and classify the step from the last legal phase.
    always_comb begin
        pop = 4'd0;
        for (int i = 0; i < 8; i++) begin
            pop = pop + 4'(bus.jc_in[i]);
        end
        inv = ~bus.jc_in;
        // Ones packed at the LSB (x & (x+1) == 0) or, for bit7 set, zeros packed at the LSB.
        if (bus.jc_in[7]) begin
            code_legal = ((inv & (inv + 8'd1)) == 8'd0);
            code_phase = 4'(5'd16 - {1'b0, pop});
        end else begin
            code_legal = ((bus.jc_in & (bus.jc_in + 8'd1)) == 8'd0);
            code_phase = pop;
        end
        step     = code_phase - phase_q;
        step_fwd = (step == 4'd1);
`ifdef JT_REVERSE_EN
        step_rev = (step == 4'hF);
        wrap_rev = step_rev && (phase_q == 4'd0);
`else
        step_rev = 1'b0;
`endif
        step_move = step_fwd | step_rev;
        dir_new   = step_fwd;
        // A unit step against the current direction is treated as a bad step.
        step_turn = have_prev & step_move & (dir_new != dir_q);
        step_good = have_prev & step_move & ~step_turn;
        step_bad  = have_prev & (step != 4'd0) & ~step_good;
        wrap_fwd  = step_fwd && (phase_q == 4'hF);
    end

    // Lock FSM, registered outputs and counters, updated on each qualified sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_UNLOCK;
            good_cnt      <= 4'd0;
            have_prev     <= 1'b0;
            phase_q       <= 4'd0;
            phase_valid_q <= 1'b0;
            illegal_q     <= 1'b0;
            dir_q         <= 1'b1;
            rev_q         <= '0;
            err_q         <= 8'd0;
        end else begin
            phase_valid_q <= 1'b0;
            illegal_q     <= 1'b0;
            if (bus.jc_valid) begin
                if (!code_legal) begin
                    illegal_q <= 1'b1;
                    if (err_q != 8'hFF) begin
                        err_q <= err_q + 8'd1;
                    end
                    state     <= ST_UNLOCK;
                    have_prev <= 1'b0;
                    good_cnt  <= 4'd0;
                end else begin
                    phase_valid_q <= 1'b1;
                    phase_q       <= code_phase;
                    have_prev     <= 1'b1;
                    if (state == ST_UNLOCK || !have_prev) begin
                        state    <= ST_ACQ;
                        good_cnt <= 4'd0;
                    end else if (step_good) begin
                        dir_q <= dir_new;
                        if (state == ST_LOCKED) begin
                            if (wrap_fwd) begin
                                rev_q <= rev_q + 1'b1;
                            end
`ifdef JT_REVERSE_EN
                            else if (wrap_rev) begin
                                rev_q <= rev_q - 1'b1;
                            end
`endif
                        end else if (good_cnt + 4'd1 == 4'(LOCK_CNT)) begin
                            state    <= ST_LOCKED;
                            good_cnt <= 4'd0;
                        end else begin
                            good_cnt <= good_cnt + 4'd1;
                        end
                    end else if (step_bad) begin
                        state    <= ST_ACQ;
                        good_cnt <= 4'd0;
                        if (step_turn) begin
                            dir_q <= dir_new;
                        end
                    end
                end
            end
        end
    end

    assign bus.phase       = phase_q;
    assign bus.phase_valid = phase_valid_q;
    assign bus.illegal     = illegal_q;
    assign bus.locked      = (state == ST_LOCKED);
    assign bus.dir         = dir_q;
    assign bus.rev_count   = rev_q;
    assign bus.err_count   = err_q;

endmodule

// File: tb/tb_johnson_phase_tracker.sv
// Self-checking bench for johnson_phase_tracker with a behavioural
// reference model built from the canonical Johnson sequence table.
module tb_johnson_phase_tracker;
    localparam int LOCK_CNT = 4;
    localparam int REV_W    = 8;
`ifdef JT_REVERSE_EN
    localparam bit REV_EN = 1'b1;
`else
    localparam bit REV_EN = 1'b0;
`endif

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    johnson_phase_tracker_if #(.REV_W(REV_W)) bus ();

    johnson_phase_tracker #(.LOCK_CNT(LOCK_CNT), .REV_W(REV_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    logic [7:0] seq [16];
    int m_state;        // 0 unlock, 1 acquiring, 2 locked
    int m_good;
    bit m_have_prev;
    int m_phase;
    bit m_pv;
    bit m_ill;
    bit m_dir;
    int m_rev;
    int m_err;

    wire [23:0] dut_vec = {bus.phase, bus.phase_valid, bus.illegal, bus.locked,
                           bus.dir, bus.rev_count, bus.err_count};

    function automatic logic [23:0] model_vec();
        logic [3:0] ph;
        logic [7:0] rv;
        logic [7:0] er;
        ph = 4'(m_phase);
        rv = 8'(m_rev);
        er = 8'(m_err);
        return {ph, m_pv, m_ill, (m_state == 2), m_dir, rv, er};
    endfunction

    function automatic int lookup(input logic [7:0] code);
        for (int k = 0; k < 16; k++) begin
            if (seq[k] == code) return k;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_state = 0; m_good = 0; m_have_prev = 0; m_phase = 0;
        m_pv = 0; m_ill = 0; m_dir = 1; m_rev = 0; m_err = 0;
    endtask

    task automatic model_step(input logic [7:0] code, input bit valid);
        int idx;
        int d;
        bit fwd;
        bit bwd;
        m_pv  = 0;
        m_ill = 0;
        if (!valid) return;
        idx = lookup(code);
        if (idx < 0) begin
            m_ill = 1;
            if (m_err < 255) m_err++;
            m_state = 0; m_have_prev = 0; m_good = 0;
            return;
        end
        m_pv = 1;
        if (m_state == 0 || !m_have_prev) begin
            m_state = 1; m_good = 0;
        end else begin
            d   = (idx - m_phase + 16) % 16;
            fwd = (d == 1);
            bwd = REV_EN && (d == 15);
            if (fwd || bwd) begin
                if (fwd != m_dir) begin
                    m_dir = fwd; m_state = 1; m_good = 0;
                end else if (m_state == 2) begin
                    if (fwd && m_phase == 15) m_rev = (m_rev + 1) % (1 << REV_W);
                    if (bwd && m_phase == 0)  m_rev = (m_rev + (1 << REV_W) - 1) % (1 << REV_W);
                end else begin
                    m_good++;
                    if (m_good == LOCK_CNT) begin
                        m_state = 2; m_good = 0;
                    end
                end
            end else if (d != 0) begin
                m_state = 1; m_good = 0;
            end
        end
        m_phase = idx;
        m_have_prev = 1;
    endtask

    task automatic apply(input logic [7:0] code, input bit valid);
        @(negedge clk);
        bus.jc_in    = code;
        bus.jc_valid = valid;
        @(posedge clk);
        model_step(code, valid);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.jc_valid = 1'b0;
        bus.jc_in = 8'h00;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++;
        if (dut_vec !== 24'h010000) begin
            errors++;
            $display("FAIL reset_values: got %h expected %h", dut_vec, 24'h010000);
        end
    endtask

    task automatic test_forward_lock();
        for (int k = 0; k <= 4; k++) begin
            apply(seq[k], 1'b1);
            checks++;
            if (dut_vec !== model_vec()) begin
                errors++;
                $display("FAIL fwd_lock k=%0d: got %h expected %h", k, dut_vec, model_vec());
            end
            checks++;
            if (bus.phase !== 4'(k) || bus.illegal !== 1'b0 || bus.locked !== (k == 4)) begin
                errors++;
                $display("FAIL fwd_lock_const k=%0d: got phase=%0d ill=%b lock=%b expected phase=%0d ill=0 lock=%b",
                         k, bus.phase, bus.illegal, bus.locked, k, (k == 4));
            end
        end
    endtask

    task automatic test_revolutions();
        logic [3:0] held;
        for (int n = 0; n < 28; n++) begin
            apply(seq[(5 + n) % 16], 1'b1);
            checks++;
            if (dut_vec !== model_vec()) begin
                errors++;
                $display("FAIL rev_walk n=%0d: got %h expected %h", n, dut_vec, model_vec());
            end
            if (n == 10) begin
                held = bus.phase;
                apply(8'h00, 1'b0);
                checks++;
                if (bus.phase_valid !== 1'b0 || bus.phase !== held || bus.locked !== 1'b1) begin
                    errors++;
                    $display("FAIL valid_low_hold: got pv=%b phase=%0d lock=%b expected pv=0 phase=%0d lock=1",
                             bus.phase_valid, bus.phase, bus.locked, held);
                end
            end
        end
        checks++;
        if (bus.rev_count !== 8'd2 || bus.phase !== 4'd0) begin
            errors++;
            $display("FAIL rev_count_two: got rev=%0d phase=%0d expected rev=2 phase=0", bus.rev_count, bus.phase);
        end
    endtask

    task automatic test_illegal();
        apply(8'h05, 1'b1);
        checks++;
        if (bus.illegal !== 1'b1 || bus.err_count !== 8'd1 || bus.locked !== 1'b0 ||
            bus.phase !== 4'd0 || bus.phase_valid !== 1'b0) begin
            errors++;
            $display("FAIL illegal_pulse: got ill=%b err=%0d lock=%b phase=%0d pv=%b expected 1 1 0 0 0",
                     bus.illegal, bus.err_count, bus.locked, bus.phase, bus.phase_valid);
        end
        for (int k = 1; k <= 5; k++) begin
            apply(seq[k], 1'b1);
            checks++;
            if (dut_vec !== model_vec() || bus.illegal !== 1'b0 || bus.locked !== (k == 5)) begin
                errors++;
                $display("FAIL illegal_recover k=%0d: got %h expected %h", k, dut_vec, model_vec());
            end
        end
    endtask

    task automatic test_skip_hold();
        apply(seq[6], 1'b1);
        apply(seq[8], 1'b1);
        checks++;
        if (bus.locked !== 1'b0 || bus.err_count !== 8'd1 || bus.phase !== 4'd8 || bus.illegal !== 1'b0) begin
            errors++;
            $display("FAIL skip_unlock: got lock=%b err=%0d phase=%0d expected lock=0 err=1 phase=8",
                     bus.locked, bus.err_count, bus.phase);
        end
        for (int r = 0; r < 2; r++) begin
            apply(seq[8], 1'b1);
            checks++;
            if (dut_vec !== model_vec() || bus.phase_valid !== 1'b1 || bus.locked !== 1'b0) begin
                errors++;
                $display("FAIL hold_repeat r=%0d: got %h expected %h", r, dut_vec, model_vec());
            end
        end
    endtask

    task automatic test_saturate_async_reset();
        logic [7:0] c;
        for (int n = 0; n < 310; n++) begin
            do c = 8'($urandom_range(0, 255)); while (lookup(c) >= 0);
            apply(c, 1'b1);
        end
        checks++;
        if (bus.err_count !== 8'd255 || m_err != 255) begin
            errors++;
            $display("FAIL err_saturate: got %0d expected 255", bus.err_count);
        end
        apply(seq[0], 1'b1);
        apply(seq[1], 1'b1);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        checks++;
        if (dut_vec !== 24'h010000) begin
            errors++;
            $display("FAIL async_reset: got %h expected %h", dut_vec, 24'h010000);
        end
        @(negedge clk);
        rst = 1'b0;
        bus.jc_valid = 1'b0;
    endtask

    task automatic test_random();
        int cur;
        int sel;
        cur = 0;
        for (int n = 0; n < 400; n++) begin
            sel = int'($urandom_range(0, 99));
            if (sel < 60)      begin cur = (cur + 1) % 16; apply(seq[cur], 1'b1); end
            else if (sel < 70) begin cur = (cur + 15) % 16; apply(seq[cur], 1'b1); end
            else if (sel < 78) apply(seq[cur], 1'b1);
            else if (sel < 88) apply(8'($urandom_range(0, 255)), 1'b1);
            else               apply(8'($urandom_range(0, 255)), 1'b0);
            checks++;
            if (dut_vec !== model_vec()) begin
                errors++;
                $display("FAIL random n=%0d: got %h expected %h", n, dut_vec, model_vec());
            end
        end
    endtask

`ifdef JT_REVERSE_EN
    task automatic test_reverse();
        do_reset();
        for (int k = 0; k <= 16; k++) apply(seq[k % 16], 1'b1);
        checks++;
        if (bus.locked !== 1'b1 || bus.rev_count !== 8'd1) begin
            errors++;
            $display("FAIL rev_prelock: got lock=%b rev=%0d expected lock=1 rev=1", bus.locked, bus.rev_count);
        end
        apply(seq[15], 1'b1);
        checks++;
        if (bus.locked !== 1'b0) begin
            errors++;
            $display("FAIL rev_turn_unlock: got lock=%b expected 0", bus.locked);
        end
        for (int k = 14; k >= 11; k--) apply(seq[k], 1'b1);
        checks++;
        if (bus.locked !== 1'b1 || bus.dir !== 1'b0) begin
            errors++;
            $display("FAIL rev_lock: got lock=%b dir=%b expected lock=1 dir=0", bus.locked, bus.dir);
        end
        for (int k = 10; k >= 0; k--) apply(seq[k], 1'b1);
        apply(seq[15], 1'b1);
        checks++;
        if (bus.rev_count !== 8'd0 || bus.locked !== 1'b1 || dut_vec !== model_vec()) begin
            errors++;
            $display("FAIL rev_decrement: got rev=%0d vec=%h expected rev=0 vec=%h", bus.rev_count, dut_vec, model_vec());
        end
    endtask
`endif

    initial begin
        logic [7:0] c;
        errors = 0;
        checks = 0;
        rst = 1'b1;
        bus.jc_in = 8'h00;
        bus.jc_valid = 1'b0;
        c = 8'h00;
        for (int k = 0; k < 16; k++) begin
            seq[k] = c;
            c = {c[6:0], ~c[7]};
        end
        model_reset();
        test_reset();
        test_forward_lock();
        test_revolutions();
        test_illegal();
        test_skip_hold();
        test_saturate_async_reset();
        do_reset();
        test_random();
`ifdef JT_REVERSE_EN
        test_reverse();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
